// File: rtl/time_alarm.sv
// Memory-mapped compare/alarm timer: one-shot or periodic match against a free-running
// timestamp, with a single-cycle-acknowledge bus and a level interrupt.
module time_alarm #(
  parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
  parameter logic [31:0] RESET_PERIOD = 32'd1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] time_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  typedef enum logic {StIdle, StAck} state_e;

  localparam logic [2:0] RegTime   = 3'd0;
  localparam logic [2:0] RegCmp    = 3'd1;
  localparam logic [2:0] RegPeriod = 3'd2;
  localparam logic [2:0] RegCtrl   = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  state_e      state_q, state_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic        pending_q, pending_d;
  logic        missed_q, missed_d;
  logic        armed_q, armed_d;
  logic        irq_q;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic        wr_en;
  logic [2:0]  reg_idx;
  logic [31:0] diff;
  logic        due;
  logic        fire;
  logic        sts_clr_pending;
  logic        sts_clr_missed;

  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Only one request is taken per IDLE->ACK round trip; requests seen in ACK are ignored.
  assign hit     = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]) && (state_q == StIdle);
  assign wr_en   = hit && (mem_wstrb != 4'b0000);
  assign reg_idx = mem_addr[4:2];

  // Wrap-aware "time_in has reached cmp" test.
  assign diff = time_in - cmp_q;
  assign due  = ~diff[31];
  assign fire = en_q && armed_q && due;

  assign sts_clr_pending = wr_en && (reg_idx == RegStatus) && mem_wstrb[0] && mem_wdata[0];
  assign sts_clr_missed  = wr_en && (reg_idx == RegStatus) && mem_wstrb[0] && mem_wdata[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (reg_idx)
      RegTime:   rdata_d = time_in;
      RegCmp:    rdata_d = cmp_q;
      RegPeriod: rdata_d = period_q;
      RegCtrl:   rdata_d = {29'd0, irq_en_q, periodic_q, en_q};
      RegStatus: rdata_d = {30'd0, missed_q, pending_q};
      default:   rdata_d = '0;
    endcase
  end

  // Order matters: W1C first, then fire (set wins), then bus writes (CMP write wins).
  always_comb begin
    cmp_d      = cmp_q;
    period_d   = period_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    armed_d    = armed_q;
    pending_d  = pending_q & ~sts_clr_pending;
    missed_d   = missed_q & ~sts_clr_missed;

    if (fire) begin
      pending_d = 1'b1;
      if (pending_q) missed_d = 1'b1;
      if (periodic_q) begin
        cmp_d = cmp_q + period_q;
      end else begin
        armed_d = 1'b0;
        en_d    = 1'b0;
      end
    end

    if (wr_en) begin
      case (reg_idx)
        RegCmp: begin
          cmp_d   = apply_strb(cmp_q, mem_wdata, mem_wstrb);
          armed_d = 1'b1;
        end
        RegPeriod: period_d = apply_strb(period_q, mem_wdata, mem_wstrb);
        RegCtrl: begin
          if (mem_wstrb[0]) begin
            en_d       = mem_wdata[0];
            periodic_d = mem_wdata[1];
            irq_en_d   = mem_wdata[2];
          end
          if (en_d) armed_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cmp_q      <= '0;
      period_q   <= RESET_PERIOD;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      missed_q   <= 1'b0;
      armed_q    <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      missed_q   <= missed_d;
      armed_q    <= armed_d;
      irq_q      <= pending_q & irq_en_q;
      if (hit) rdata_q <= rdata_d;
    end
  end

  assign mem_ready = (state_q == StAck);
  assign mem_rdata = (state_q == StAck) ? rdata_q : 32'd0;
  assign irq       = irq_q;

endmodule
